// File: rtl/cryptoveril_forward.sv
`default_nettype none
// ============================================================================
//  Module   : cryptoveril_forward
//  Purpose  : 3-stage encryption pipeline (shift-add, mode logic, cleanup)
//             with valid/ready handshakes. Each word carries its own key,
//             which is forwarded on out_key for the downstream decryptor.
//  Options  : CRYPTO_STATS_EN adds the CNT_W parameter and a saturating
//             word_count output of completed output handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module cryptoveril_forward
`ifdef CRYPTO_STATS_EN
#(
   parameter int CNT_W = 16
)
`endif
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_data,
   input  logic [5:0]        in_key,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_data,
   output logic [5:0]        out_key,
`ifdef CRYPTO_STATS_EN
   output logic [CNT_W-1:0]  word_count,
`endif
   output logic              busy
);

   localparam logic [1:0] MODE_PARITY = 2'd0;
   localparam logic [1:0] MODE_AND    = 2'd1;
   localparam logic [1:0] MODE_OR     = 2'd2;
   localparam logic [1:0] MODE_SEXT   = 2'd3;

   logic        v1, v2, v3;
   logic [15:0] d1, d2, d3;
   logic [5:0]  k1, k2, k3;
   logic        ready1, ready2, ready3;
   logic [2:0]  shamt;
   logic [15:0] s1_calc, s2_calc, s3_calc;

   // Ready chain: a stage can take a word if it is empty or its word moves on
   always_comb begin
      ready3   = !v3 || out_ready;
      ready2   = !v2 || ready3;
      ready1   = !v1 || ready2;
      in_ready = ready1 && !flush;
   end

   // Stage 1 arithmetic: shift by s, then add s (mod 2^16)
   always_comb begin
      shamt   = in_key[5:3];
      s1_calc = (in_data << shamt) + {13'd0, shamt};
   end

   // Stage 2 mode logic, selected by the key travelling with the S1 word
   always_comb begin
      s2_calc = d1;
      case (k1[2:1])
         MODE_PARITY: s2_calc = {15'd0, ^d1};
         MODE_AND:    s2_calc = d1 & 16'hAAAA;
         MODE_OR:     s2_calc = d1 | 16'h5555;
         MODE_SEXT:   s2_calc = {{4{d1[11]}}, d1[11:0]};
         default:     s2_calc = d1;
      endcase
   end

   // Stage 3 cleanup: mode 3 strips the sign extension added in stage 2
   always_comb begin
      s3_calc = (k2[2:1] == MODE_SEXT) ? {4'd0, d2[11:0]} : d2;
   end

   // Stage valid bits; flush empties the pipe and drops any offered word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else if (flush) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         if (ready1) v1 <= in_valid;
         if (ready2) v2 <= v1;
         if (ready3) v3 <= v2;
      end
   end

   // Stage data/key registers; load only real words so idle outputs stay quiet
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d1 <= '0; k1 <= '0;
         d2 <= '0; k2 <= '0;
         d3 <= '0; k3 <= '0;
      end else if (!flush) begin
         if (ready1 && in_valid) begin
            d1 <= s1_calc;
            k1 <= in_key;
         end
         if (ready2 && v1) begin
            d2 <= s2_calc;
            k2 <= k1;
         end
         if (ready3 && v2) begin
            d3 <= s3_calc;
            k3 <= k2;
         end
      end
   end

   assign out_valid = v3;
   assign out_data  = d3;
   assign out_key   = k3;
   assign busy      = v1 | v2 | v3;

`ifdef CRYPTO_STATS_EN
   // Saturating count of completed output handshakes, cleared by flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_count <= '0;
      end else if (flush) begin
         word_count <= '0;
      end else if (out_valid && out_ready && (word_count != {CNT_W{1'b1}})) begin
         word_count <= word_count + 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cryptoveril_forward.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cryptoveril_forward
//  Purpose  : Directed self-checking bench for cryptoveril_forward.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cryptoveril_forward;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = 16'h0;
   logic [5:0]  in_key = 6'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic [5:0]  out_key;
   logic        busy;
`ifdef CRYPTO_STATS_EN
   logic [1:0]  word_count;
`endif

   int errors = 0;
   int checks = 0;

`ifdef CRYPTO_STATS_EN
   cryptoveril_forward #(.CNT_W(2)) dut (
`else
   cryptoveril_forward dut (
`endif
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_key     (in_key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_key    (out_key),
`ifdef CRYPTO_STATS_EN
      .word_count (word_count),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Advance one clock; land 2 time units after the rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      int lat;
      rst_n = 1'b0; in_valid = 1'b1; in_data = 16'h1234; in_key = 6'h0B;
      out_ready = 1'b1; flush = 1'b0;
      repeat (3) tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
      checks++; if (out_key !== 6'h00) begin errors++; $display("FAIL reset_out_key: got %h expected 00", out_key); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      in_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      // First accept: 0x0012 with s=3, m=1 -> 0x0082
      in_valid = 1'b1; in_data = 16'h0012; in_key = 6'b011_01_0;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      checks++; if (lat !== 3) begin errors++; $display("FAIL first_latency: got %0d expected 3", lat); end
      checks++; if (out_data !== 16'h0082) begin errors++; $display("FAIL first_data: got %h expected 0082", out_data); end
      tick();
   endtask

   task automatic test_modes();
      logic [15:0] din  [4];
      logic [5:0]  kin  [4];
      logic [15:0] dexp [4];
      int in_idx, out_idx;
      bit acc;
      din[0] = 16'h0012; kin[0] = 6'b011_01_0; dexp[0] = 16'h0082;
      din[1] = 16'h0001; kin[1] = 6'b000_10_0; dexp[1] = 16'h5555;
      din[2] = 16'h0007; kin[2] = 6'b000_00_0; dexp[2] = 16'h0001;
      din[3] = 16'h0801; kin[3] = 6'b000_11_0; dexp[3] = 16'h0801;
      out_ready = 1'b1;
      in_idx = 0; out_idx = 0;
      for (int cyc = 0; cyc < 20 && out_idx < 4; cyc++) begin
         if (in_idx < 4) begin
            in_valid = 1'b1; in_data = din[in_idx]; in_key = kin[in_idx];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            checks++; if (out_data !== dexp[out_idx]) begin errors++; $display("FAIL mode_data[%0d]: got %h expected %h", out_idx, out_data, dexp[out_idx]); end
            checks++; if (out_key !== kin[out_idx]) begin errors++; $display("FAIL mode_key[%0d]: got %b expected %b", out_idx, out_key, kin[out_idx]); end
            out_idx++;
         end
         tick();
         if (acc) in_idx++;
      end
      in_valid = 1'b0;
      checks++; if (out_idx !== 4) begin errors++; $display("FAIL mode_count: got %0d expected 4", out_idx); end
   endtask

   task automatic test_backpressure();
      logic [15:0] din  [4];
      logic [5:0]  kin  [4];
      logic [15:0] dexp [4];
      int in_idx, out_idx;
      bit acc;
      din[0] = 16'h1234; kin[0] = 6'b001_01_1; dexp[0] = 16'h2028;
      din[1] = 16'h00FF; kin[1] = 6'b010_10_0; dexp[1] = 16'h57FF;
      din[2] = 16'h8001; kin[2] = 6'b111_00_1; dexp[2] = 16'h0000;
      din[3] = 16'h0A5F; kin[3] = 6'b100_11_0; dexp[3] = 16'h05F4;
      out_ready = 1'b0;
      in_idx = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (in_idx < 4) begin
            in_valid = 1'b1; in_data = din[in_idx]; in_key = kin[in_idx];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         acc = in_valid && in_ready;
         if (out_valid) begin
            checks++; if (out_data !== dexp[0]) begin errors++; $display("FAIL bp_hold_data: got %h expected %h", out_data, dexp[0]); end
            checks++; if (out_key !== kin[0]) begin errors++; $display("FAIL bp_hold_key: got %b expected %b", out_key, kin[0]); end
         end
         tick();
         if (acc) in_idx++;
      end
      #1;
      checks++; if (in_idx !== 3) begin errors++; $display("FAIL bp_accepted: got %0d expected 3", in_idx); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
      // Release backpressure and drain in order
      out_ready = 1'b1;
      out_idx = 0;
      for (int cyc = 0; cyc < 20 && out_idx < 4; cyc++) begin
         if (in_idx < 4) begin
            in_valid = 1'b1; in_data = din[in_idx]; in_key = kin[in_idx];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            checks++; if (out_data !== dexp[out_idx]) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", out_idx, out_data, dexp[out_idx]); end
            checks++; if (out_key !== kin[out_idx]) begin errors++; $display("FAIL bp_key[%0d]: got %b expected %b", out_idx, out_key, kin[out_idx]); end
            out_idx++;
         end
         tick();
         if (acc) in_idx++;
      end
      in_valid = 1'b0;
      #1;
      checks++; if (out_idx !== 4) begin errors++; $display("FAIL bp_drain_count: got %0d expected 4", out_idx); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate: got out_valid=%b expected 0", out_valid); end
      tick();
   endtask

   task automatic test_flush();
      int hs;
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 16'h0101; in_key = 6'b001_01_0;
      tick();
      in_data = 16'h0202; in_key = 6'b010_10_0;
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before: got %b expected 1", busy); end
      flush = 1'b1; in_data = 16'h0303; in_key = 6'b000_00_0;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b expected 0", busy); end
`ifdef CRYPTO_STATS_EN
      checks++; if (word_count !== 2'd0) begin errors++; $display("FAIL flush_word_count: got %0d expected 0", word_count); end
`endif
      hs = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (out_valid && out_ready) hs++;
         tick();
      end
      checks++; if (hs !== 0) begin errors++; $display("FAIL flush_no_output: got %0d handshakes expected 0", hs); end
   endtask

   task automatic test_reset_midstream();
      int hs;
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 16'h0404; in_key = 6'b001_00_0;
      tick();
      in_data = 16'h0505; in_key = 6'b011_11_1;
      tick();
      in_valid = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %b expected 1", busy); end
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_after: got %b expected 0", busy); end
      checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rst_out_data: got %h expected 0000", out_data); end
`ifdef CRYPTO_STATS_EN
      checks++; if (word_count !== 2'd0) begin errors++; $display("FAIL rst_word_count: got %0d expected 0", word_count); end
`endif
      hs = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (out_valid && out_ready) hs++;
         tick();
      end
      checks++; if (hs !== 0) begin errors++; $display("FAIL rst_no_output: got %0d handshakes expected 0", hs); end
   endtask

`ifdef CRYPTO_STATS_EN
   task automatic test_stats_saturation();
      int n;
      bit hs, acc;
      int sent;
      logic [1:0] exp_cnt;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (word_count !== 2'd0) begin errors++; $display("FAIL stats_clear: got %0d expected 0", word_count); end
      out_ready = 1'b1;
      n = 0; sent = 0;
      for (int cyc = 0; cyc < 20 && n < 5; cyc++) begin
         if (sent < 5) begin
            in_valid = 1'b1; in_data = 16'h0010 + 16'(sent); in_key = 6'b000_01_0;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         acc = in_valid && in_ready;
         hs = out_valid && out_ready;
         tick();
         if (acc) sent++;
         if (hs) begin
            n++;
            exp_cnt = (n > 3) ? 2'd3 : 2'(n);
            checks++; if (word_count !== exp_cnt) begin errors++; $display("FAIL stats_count[%0d]: got %0d expected %0d", n, word_count, exp_cnt); end
         end
      end
      in_valid = 1'b0;
      checks++; if (n !== 5) begin errors++; $display("FAIL stats_handshakes: got %0d expected 5", n); end
   endtask
`endif

   initial begin
      test_reset();
      test_modes();
      test_backpressure();
      test_flush();
      test_reset_midstream();
`ifdef CRYPTO_STATS_EN
      test_stats_saturation();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cryptoveril_forward.md
Name: cryptoveril_forward

Overview:
- Single-clock, 3-stage encryption pipeline with valid/ready handshakes.
- Produces the encrypted word stream consumed by the decrypt pipeline:
  - stage 1: shift-add
  - stage 2: mode logic
  - stage 3: cleanup
- The key travels with each word, so every word is encrypted under its own key.
- `out_key` is forwarded downstream for the decryptor.

Parameters:
- CNT_W, 16, width of the optional statistics counter. Used only with CRYPTO_STATS_EN.

Ports:
- clk  input  1  rising-edge clock; sole clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline clear.
- in_valid  input  1  in_data/in_key valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  16  plaintext word.
- in_key  input  6  key. [5:3] = shift amount s; [2:1] = mode m; [0] = reserved, carried through.
- out_valid  output  1  out_data/out_key valid.
- out_ready  input  1  downstream accepts.
- out_data  output  16  encrypted word.
- out_key  output  6  key the word was encrypted with.
- busy  output  1  any stage holds a valid word.
- word_count  output  CNT_W  present only with CRYPTO_STATS_EN.

Behaviour:
- Reset (rst_n low, async):
  - all stage valids = 0; all stage data/key registers = 0.
  - out_valid = 0, out_data = 0, out_key = 0, busy = 0.
  - in_ready = 1 one cycle after release.
- Pipeline: three register stages S1, S2, S3, each with {valid, data[15:0], key[5:0]}. S3 drives the outputs.
- Ready chaining:
  - ready3 = !v3 | out_ready
  - ready2 = !v2 | ready3
  - ready1 = !v1 | ready2
  - in_ready = ready1
- Transfer and advance:
  - Input transfer occurs on in_valid & in_ready.
  - A stage loads from its predecessor when its own ready is 1.
  - It becomes empty if the predecessor is invalid.
- Latency and throughput:
  - Accept at cycle N gives out_valid at N+3 with no stall.
  - Throughput is 1 word/cycle.
  - Capacity is 3 words.
- While out_valid & !out_ready, out_data and out_key hold stable.
- Stage 1 arithmetic: s1 = ((in_data << s) + s) mod 2^16, with s zero-extended.
- Stage 2 (m taken from S1's key):
  - m=0: {15'd0, ^s1} (parity)
  - m=1: s1 & 16'hAAAA
  - m=2: s1 | 16'h5555
  - m=3: {{4{s1[11]}}, s1[11:0]}
- Stage 3 (m taken from S2's key):
  - m=3: {4'd0, s2[11:0]}
  - otherwise passthrough.
- Key handling: the key is registered alongside data in every stage. The in_key sampled at input handshake is the only key used for that word; in_key changes between words take effect per word.
- flush:
  - Clears v1..v3 next edge; data registers are don't-care.
  - flush wins over a simultaneous input handshake; that word is dropped.
  - in_ready is forced 0 during flush.
- busy = v1 | v2 | v3.
- Reset mid-stream: all in-flight words are discarded. No output handshake occurs until new input has traversed all 3 stages.

Optional Feature:
- Macro: CRYPTO_STATS_EN.
- Defined:
  - Output word_count exists.
  - Reset to 0 by rst_n and by flush.
  - Increments by 1 on each out_valid & out_ready.
  - Saturates at 2^CNT_W-1 (no wrap).
- Undefined: the word_count port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 while in_valid=1 → out_valid=0, out_data=16'h0000, busy=0. After release, in_ready=1 and the first output appears exactly 3 cycles after first accept.
- Modes, with out_ready=1:
  - in_data=16'h0012, in_key=6'b011_01_0 → out_data=16'h0082
  - in_data=16'h0001, in_key=6'b000_10_0 → out_data=16'h5555
  - in_data=16'h0007, in_key=6'b000_00_0 → out_data=16'h0001
- Mode 3 cleanup: in_data=16'h0801, in_key=6'b000_11_0 → stage2 value 16'hF801, out_data=16'h0801, out_key=6'b000110.
- Backpressure: out_ready=0, stream words A, B, C, D back-to-back → A, B, C accepted, in_ready=0 on D, out_data=A held stable. Raise out_ready → A, B, C, D emerged in order, no loss or duplication.
- Flush/reset mid-stream: 2 words in flight, pulse flush → busy=0 next cycle, no output handshake, word_count=0 (stats build). Repeat with rst_n pulse mid-cycle → same result.
- Stats saturation (CRYPTO_STATS_EN, CNT_W=2): 5 output handshakes → word_count sequence 1, 2, 3, 3, 3.
